// File: rtl/sync_filter_bank.sv
// ============================================================================
// Module   : sync_filter_bank
// Purpose  : Per-channel synchroniser, glitch filter, edge detector and
//            sticky event flag for asynchronous pad-level inputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_filter_bank #(
    parameter int CH     = 8,
    parameter int STAGES = 2,
    parameter int FILT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [CH-1:0]     async_in,
    input  logic [2*CH-1:0]   mode,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [CH-1:0]     evt_clr,
    output logic [CH-1:0]     level_out,
    output logic [CH-1:0]     pulse_out,
    output logic [CH-1:0]     evt_flag,
    output logic              any_evt
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [STAGES-1:0] r_sync;
        logic              r_level;
        logic [FILT_W-1:0] r_cnt;
        logic              r_pulse;
        logic              r_flag;
        logic              w_s;
        logic [1:0]        w_mode;

        assign w_s    = r_sync[STAGES-1];
        assign w_mode = mode[2*i+1:2*i];

        // Synchroniser free-runs so the chain is always settled when ena returns.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[STAGES-2:0], async_in[i]};
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_level <= 1'b0;
                r_cnt   <= '0;
                r_pulse <= 1'b0;
                r_flag  <= 1'b0;
            end else begin
                r_pulse <= 1'b0;
                if (ena) begin
                    if (w_s == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt < filt_len) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        // ">=" lets a lowered filt_len accept at once instead of wrapping
                        r_level <= w_s;
                        r_cnt   <= '0;
                        r_pulse <= w_s ? w_mode[0] : w_mode[1];
                    end
                end
                // A pulse wins over a coincident clear so no event is dropped.
                r_flag <= (r_flag & ~(ena & evt_clr[i])) | r_pulse;
            end
        end

        assign level_out[i] = r_level;
        assign pulse_out[i] = r_pulse;
        assign evt_flag[i]  = r_flag;
    end

    assign any_evt = |evt_flag;

endmodule

`default_nettype wire
